// File: rtl/hdmi_mode_sequencer.sv
// Debounces the requested video standard and sequences a clean switch of the HDMI
// cores: frame-aligned reset pulse, then blank/mute until the new timing settles.
module hdmi_mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int RESET_CYCLES    = 16,
  parameter int SETTLE_FRAMES   = 2,
  parameter int FRAME_TIMEOUT   = 1048575
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        pal_mode_req,
  input  logic [10:0] cx,
  input  logic [9:0]  cy,
  output logic        pal_mode,
  output logic        hdmi_reset,
  output logic        video_blank,
  output logic        audio_mute,
  output logic        busy
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > RESET_CYCLES) ? DEBOUNCE_CYCLES : RESET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int TMR_W   = $clog2(FRAME_TIMEOUT) + 1;
  localparam int FRM_W   = $clog2(SETTLE_FRAMES) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FRAME_TIMEOUT - 1);
  localparam logic [FRM_W-1:0] FRM_ONE  = FRM_W'(1);
  localparam logic [FRM_W-1:0] FRM_DONE = FRM_W'(SETTLE_FRAMES);

  typedef enum logic [2:0] {IDLE, DEBOUNCE, WAIT_FRAME, RESETTING, SETTLE} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [FRM_W-1:0] frames, frames_n, frames_inc;
  logic             pal_n;
  logic             frame_start, frame_start_d, frame_pulse;

  // Reset value of 1 keeps a 0,0 position held across reset from looking like a new frame
  assign frame_start = (cx == 11'd0) && (cy == 10'd0);
  assign frame_pulse = frame_start && !frame_start_d;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    timer_n    = timer;
    frames_n   = frames;
    pal_n      = pal_mode;
    frames_inc = frames + FRM_ONE;
    case (state)
      IDLE: begin
        if (pal_mode_req != pal_mode) begin
          state_n = DEBOUNCE;
          cnt_n   = CNT_ONE;
        end
      end
      DEBOUNCE: begin
        if (pal_mode_req == pal_mode) begin
          state_n = IDLE;
        end else if (cnt == DEB_LAST) begin
          state_n = WAIT_FRAME;
          timer_n = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      WAIT_FRAME: begin
        // A revert wins over a coincident frame boundary or timeout
        if (pal_mode_req == pal_mode) begin
          state_n = IDLE;
        end else if (frame_pulse || (timer == TMR_LAST)) begin
          state_n = RESETTING;
          pal_n   = pal_mode_req;
          cnt_n   = '0;
        end else begin
          timer_n = timer + TMR_ONE;
        end
      end
      RESETTING: begin
        if (cnt == RST_LAST) begin
          state_n  = SETTLE;
          frames_n = '0;
          timer_n  = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      SETTLE: begin
        // A missing frame pulse still counts once the timeout expires
        if (frame_pulse || (timer == TMR_LAST)) begin
          timer_n  = '0;
          frames_n = frames_inc;
          if (frames_inc == FRM_DONE) state_n = IDLE;
        end else begin
          timer_n = timer + TMR_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state         <= RESETTING;
      pal_mode      <= pal_mode_req;
      hdmi_reset    <= 1'b1;
      video_blank   <= 1'b1;
      audio_mute    <= 1'b1;
      busy          <= 1'b1;
      cnt           <= '0;
      timer         <= '0;
      frames        <= '0;
      frame_start_d <= 1'b1;
    end else begin
      state         <= state_n;
      pal_mode      <= pal_n;
      hdmi_reset    <= (state_n == RESETTING);
      video_blank   <= (state_n == WAIT_FRAME) || (state_n == RESETTING) || (state_n == SETTLE);
      audio_mute    <= (state_n == WAIT_FRAME) || (state_n == RESETTING) || (state_n == SETTLE);
      busy          <= (state_n != IDLE);
      cnt           <= cnt_n;
      timer         <= timer_n;
      frames        <= frames_n;
      frame_start_d <= frame_start;
    end
  end

endmodule

// File: tb/tb_hdmi_mode_sequencer.sv
// Directed bench for hdmi_mode_sequencer: reset, debounce/abort table, frame-aligned
// and timeout-driven switches, and reset during the HDMI reset pulse.
module tb_hdmi_mode_sequencer;

  logic        clk_pixel = 1'b0;
  logic        reset = 1'b1;
  logic        pal_mode_req = 1'b1;
  logic [10:0] cx = '0;
  logic [9:0]  cy = '0;
  logic        pal_mode, hdmi_reset, video_blank, audio_mute, busy;

  int errors = 0;
  int checks = 0;
  int pos = 0;
  bit hold = 1'b0;
  bit prev_fs = 1'b1;
  bit last_fp = 1'b0;

  hdmi_mode_sequencer #(
    .DEBOUNCE_CYCLES(8),
    .RESET_CYCLES(4),
    .SETTLE_FRAMES(2),
    .FRAME_TIMEOUT(64)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset(reset),
    .pal_mode_req(pal_mode_req),
    .cx(cx),
    .cy(cy),
    .pal_mode(pal_mode),
    .hdmi_reset(hdmi_reset),
    .video_blank(video_blank),
    .audio_mute(audio_mute),
    .busy(busy)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    logic req;
    logic pal;
    logic rst;
    logic blank;
    logic bsy;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_pos(input int p);
    pos = p;
    cx  = 11'(pos % 20);
    cy  = 10'(pos / 20);
  endtask

  // One clock: records whether the DUT sees a frame pulse on this edge, then moves the raster
  task automatic tick();
    bit fs;
    fs = (cx == 11'd0) && (cy == 10'd0);
    last_fp = fs && !prev_fs && !reset;
    @(posedge clk_pixel);
    prev_fs = reset ? 1'b1 : fs;
    #1;
    if (!hold) set_pos((pos + 1) % 200);
  endtask

  task automatic reset_pulse_check(input string nm, input logic exp_pal);
    int n;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!hdmi_reset) break;
      n++;
      chk({nm, " blank during reset"}, video_blank, 1'b1);
      chk({nm, " pal during reset"}, pal_mode, exp_pal);
    end
    chk_int({nm, " hdmi_reset cycles"}, n, 4);
  endtask

  task automatic settle_check(input string nm, input logic exp_pal, output int cyc);
    int t, frames;
    bit done;
    t = 0; frames = 0; done = 1'b0; cyc = 0;
    for (int n = 1; n <= 1000; n++) begin
      tick();
      if (last_fp || t == 63) begin
        t = 0;
        frames++;
      end else begin
        t++;
      end
      if (frames == 2) begin
        chk({nm, " unblank"}, video_blank, 1'b0);
        chk({nm, " unmute"}, audio_mute, 1'b0);
        chk({nm, " idle busy"}, busy, 1'b0);
        chk({nm, " pal after settle"}, pal_mode, exp_pal);
        cyc = n;
        done = 1'b1;
        break;
      end
      chk({nm, " settle blank"}, video_blank, 1'b1);
      chk({nm, " settle busy"}, busy, 1'b1);
      chk({nm, " settle hdmi_reset"}, hdmi_reset, 1'b0);
    end
    chk({nm, " settle finished"}, done, 1'b1);
  endtask

  task automatic do_switch(input logic nv, input string nm, output int wait_n,
                           output bit via_pulse, output int settle_n);
    int t;
    bit done;
    pal_mode_req = nv;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk({nm, " debounce busy"}, busy, 1'b1);
      chk({nm, " debounce blank"}, video_blank, 1'b0);
      chk({nm, " debounce pal"}, pal_mode, !nv);
    end
    tick();
    chk({nm, " wait blank"}, video_blank, 1'b1);
    chk({nm, " wait mute"}, audio_mute, 1'b1);
    chk({nm, " wait hdmi_reset"}, hdmi_reset, 1'b0);
    chk({nm, " wait pal"}, pal_mode, !nv);
    t = 0; done = 1'b0; wait_n = 0; via_pulse = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (last_fp || t == 63) begin
        chk({nm, " switch pal"}, pal_mode, nv);
        chk({nm, " switch hdmi_reset"}, hdmi_reset, 1'b1);
        wait_n = n;
        via_pulse = last_fp;
        done = 1'b1;
        break;
      end
      chk({nm, " waiting pal"}, pal_mode, !nv);
      chk({nm, " waiting hdmi_reset"}, hdmi_reset, 1'b0);
      t++;
    end
    chk({nm, " frame wait finished"}, done, 1'b1);
    reset_pulse_check(nm, nv);
    settle_check(nm, nv, settle_n);
  endtask

  initial begin
    int wait_n, settle_n;
    bit via_pulse;
    bit done;

    for (int i = 0; i < 21; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 15; i < 19; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset with PAL requested while the raster sits at 0,0
    set_pos(0);
    reset = 1'b1;
    pal_mode_req = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset pal", pal_mode, 1'b1);
    chk("reset hdmi_reset", hdmi_reset, 1'b1);
    chk("reset blank", video_blank, 1'b1);
    chk("reset mute", audio_mute, 1'b1);
    chk("reset busy", busy, 1'b1);
    reset_pulse_check("por", 1'b1);
    settle_check("por", 1'b1, settle_n);

    do_switch(1'b0, "to_ntsc", wait_n, via_pulse, settle_n);

    // Glitch and abort sequences with the raster frozen away from 0,0
    hold = 1'b1;
    set_pos(105);
    for (int i = 0; i < 21; i++) begin
      pal_mode_req = tbl[i].req;
      tick();
      chk($sformatf("tbl[%0d] pal", i), pal_mode, tbl[i].pal);
      chk($sformatf("tbl[%0d] hdmi_reset", i), hdmi_reset, tbl[i].rst);
      chk($sformatf("tbl[%0d] blank", i), video_blank, tbl[i].blank);
      chk($sformatf("tbl[%0d] mute", i), audio_mute, tbl[i].blank);
      chk($sformatf("tbl[%0d] busy", i), busy, tbl[i].bsy);
    end

    // Frame-aligned switch to PAL: boundary arrives 21 cycles into the wait
    hold = 1'b0;
    set_pos(171);
    do_switch(1'b1, "to_pal", wait_n, via_pulse, settle_n);
    chk("to_pal via frame pulse", via_pulse, 1'b1);
    chk_int("to_pal wait cycles", wait_n, 21);

    // Frozen raster: both the frame wait and each settle frame run to timeout
    hold = 1'b1;
    set_pos(105);
    do_switch(1'b0, "timeout", wait_n, via_pulse, settle_n);
    chk("timeout via frame pulse", via_pulse, 1'b0);
    chk_int("timeout wait cycles", wait_n, 64);
    chk_int("timeout settle cycles", settle_n, 128);

    // Reset arriving mid reset-pulse restarts the full sequence
    pal_mode_req = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (hdmi_reset) begin
        done = 1'b1;
        break;
      end
    end
    chk("rst6 reached resetting", done, 1'b1);
    chk("rst6 pal switched", pal_mode, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    pal_mode_req = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst6 pal", pal_mode, 1'b0);
    chk("rst6 hdmi_reset", hdmi_reset, 1'b1);
    chk("rst6 blank", video_blank, 1'b1);
    chk("rst6 busy", busy, 1'b1);
    reset_pulse_check("rst6", 1'b0);
    settle_check("rst6", 1'b0, settle_n);
    chk_int("rst6 settle cycles", settle_n, 128);
    tick();
    chk("final busy", busy, 1'b0);
    chk("final pal", pal_mode, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hdmi_mode_sequencer.md
Name: hdmi_mode_sequencer

Overview:
- Sits directly upstream of hdmi_selection and drives its pal_mode and hdmi_reset inputs.
- Takes the VDP's requested video standard, debounces it, then waits for a frame boundary on the cx/cy it gets back from hdmi_selection.
- Pulses the HDMI core reset while switching the standard, then holds video blank and audio mute until the new timing has run for a set number of frames.
- Keeps glitchy mode changes from corrupting TMDS output mid-frame.

Parameters:
DEBOUNCE_CYCLES, 1024, cycles pal_mode_req must differ stably from pal_mode before a switch starts (>=1)
RESET_CYCLES, 16, cycles hdmi_reset is held high per switch (>=1)
SETTLE_FRAMES, 2, frame-start pulses required after reset before unblanking (>=1)
FRAME_TIMEOUT, 1048575, max cycles waited for any single frame-start pulse before proceeding anyway

Ports:
clk_pixel  input  1  pixel clock; sole clock
reset  input  1  synchronous, active-high
pal_mode_req  input  1  requested standard from VDP register (1=PAL/VIC17, 0=NTSC/VIC2), clk_pixel domain
cx  input  11  current pixel x from hdmi_selection
cy  input  10  current pixel y from hdmi_selection
pal_mode  output  1  registered active standard, to hdmi_selection
hdmi_reset  output  1  reset to HDMI cores, registered
video_blank  output  1  1 = upstream must drive rgb=24'h000000
audio_mute  output  1  1 = upstream must drive zero audio samples
busy  output  1  1 when state != IDLE

Behaviour:
- Interface: one clock, clk_pixel. reset is synchronous and active-high.
- All outputs are registered.
- frame_start = (cx==0 && cy==0).
- frame_pulse = frame_start && !frame_start_d. frame_start_d is a register, reset to 1, so a held 0,0 during or after reset never counts.
- States: IDLE, DEBOUNCE, WAIT_FRAME, RESETTING, SETTLE.
- Reset:
  - On the next edge: state=RESETTING, pal_mode<=pal_mode_req, hdmi_reset=1, video_blank=1, audio_mute=1, busy=1, all counters=0.
  - Post-reset sequence is then identical to a normal switch from RESETTING onward.
- IDLE:
  - Outputs 0 except pal_mode.
  - If pal_mode_req!=pal_mode: go to DEBOUNCE with cnt=1.
- DEBOUNCE:
  - Outputs as IDLE, except busy=1.
  - If pal_mode_req==pal_mode: go to IDLE.
  - Else if cnt==DEBOUNCE_CYCLES: go to WAIT_FRAME with timer=0.
  - Else cnt++.
  - Net effect: a request that differs for fewer than DEBOUNCE_CYCLES consecutive cycles is ignored.
- WAIT_FRAME:
  - video_blank=1, audio_mute=1.
  - If pal_mode_req==pal_mode (aborted): go to IDLE; blank and mute drop the next cycle.
  - Else if frame_pulse or timer==FRAME_TIMEOUT-1: go to RESETTING. On that same edge pal_mode<=pal_mode_req, hdmi_reset<=1, cnt=0.
  - Else timer++.
- RESETTING:
  - hdmi_reset=1 for exactly RESET_CYCLES cycles; blank and mute stay 1.
  - Then go to SETTLE with hdmi_reset<=0, frames=0, timer=0.
  - pal_mode_req is ignored.
- SETTLE:
  - blank=1, mute=1, hdmi_reset=0.
  - frame_pulse: frames++, timer=0.
  - timer==FRAME_TIMEOUT-1: treated as a pulse.
  - When the increment makes frames==SETTLE_FRAMES: go to IDLE; blank, mute and busy clear on that edge.
  - pal_mode_req changes are ignored here and re-evaluated in IDLE, so a request made mid-settle starts a fresh DEBOUNCE.
- pal_mode changes only on the WAIT_FRAME->RESETTING edge or on reset; never at any other time.
- Width rules: counters are sized by $clog2 of their parameter +1; no wrap is possible because the compare precedes the increment.
- Simultaneous events:
  - Reset has priority over everything.
  - In WAIT_FRAME, abort has priority over frame_pulse and timeout.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=8, RESET_CYCLES=4, SETTLE_FRAMES=2, FRAME_TIMEOUT=64, and a free-running cx/cy model of a 20x10 frame.)
1. reset high 1 cycle with pal_mode_req=1 -> pal_mode=1; hdmi_reset high exactly 4 cycles; blank/mute high until the 2nd frame_pulse after reset release; busy then 0.
2. From IDLE (pal_mode=0) set pal_mode_req=1 -> pal_mode stays 0 for 8 cycles, then blank=1. pal_mode flips to 1 on the edge after the next cx=0,cy=0, together with hdmi_reset rising for 4 cycles; unblank after 2 further frame pulses.
3. Toggle pal_mode_req to 1 for 5 cycles, then back to 0 -> pal_mode, hdmi_reset and blank never change; busy high 5 cycles then 0.
4. Request PAL, then revert pal_mode_req during WAIT_FRAME before a frame boundary -> state returns to IDLE, blank/mute drop next cycle, hdmi_reset never asserted, pal_mode stays 0.
5. Hold cx=5, cy=5 constant during WAIT_FRAME -> RESETTING entered after exactly 64 cycles. In SETTLE, each frame advances after 64 cycles; IDLE reached after 128 cycles of SETTLE.
6. Assert reset during RESETTING (cnt=2) with pal_mode_req=0 -> next cycle pal_mode=0, hdmi_reset restarts a full 4-cycle pulse, blank=1.
